// File: rtl/piso_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_frame_serializer
//  Purpose  : Parallel-in / serial-out framer. Buffers one N-bit word behind
//             a valid/ready handshake and shifts words out one bit per clock,
//             MSB- or LSB-first. Flags mark valid bits and the last bit of
//             each frame.
//  Revision : 1.0  - initial release
// ============================================================================
module piso_frame_serializer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         lsb_first,
  input  logic         hold,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         serial_last,
  output logic         busy
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(N - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     pend_data;
  logic             pend_full;
  logic [N-1:0]     sr;
  logic [CNT_W-1:0] cnt;
  logic             dir;

  logic accept;
  logic last_bit;
  logic load;
  logic advance;

  // Handshake and sequencing decodes.
  // A full buffer never accepts, even in the cycle it drains into the shifter.
  assign accept   = in_valid && !pend_full;
  assign last_bit = (state == SHIFT) && (cnt == '0);
  assign load     = pend_full && !hold && ((state == IDLE) || last_bit);
  assign advance  = (state == SHIFT) && !hold && (cnt != '0);

  // Output mapping; serial_out is forced low outside a frame.
  assign in_ready     = !pend_full;
  assign serial_out   = (state == SHIFT) ? (dir ? sr[0] : sr[N-1]) : 1'b0;
  assign serial_valid = (state == SHIFT) && !hold;
  assign serial_last  = serial_valid && (cnt == '0);
  assign busy         = (state == SHIFT) || pend_full;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: enter SHIFT on any load, drop to IDLE after a last bit
  // that is not immediately followed by a back-to-back reload.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = SHIFT;
    end else if (last_bit && !hold) begin
      state_nxt = IDLE;
    end
  end

  // One-word pending buffer: filled on accept, emptied on load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_full <= 1'b0;
      pend_data <= '0;
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_data <= in_data;
    end else if (load) begin
      pend_full <= 1'b0;
    end
  end

  // Shifter, bit counter and frame direction; bit order is latched at load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
      dir <= 1'b0;
    end else if (load) begin
      sr  <= pend_data;
      cnt <= CNT_FIRST;
      dir <= lsb_first;
    end else if (advance) begin
      sr  <= dir ? {1'b0, sr[N-1:1]} : {sr[N-2:0], 1'b0};
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_frame_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_piso_frame_serializer
//  Purpose  : Directed self-checking bench for piso_frame_serializer (N=8).
//  Revision : 1.0  - initial release
// ============================================================================
module tb_piso_frame_serializer;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         lsb_first;
  logic         hold;
  logic         serial_out;
  logic         serial_valid;
  logic         serial_last;
  logic         busy;

  int passed;
  int total;

  piso_frame_serializer #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .lsb_first    (lsb_first),
    .hold         (hold),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .serial_last  (serial_last),
    .busy         (busy)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Directed sequence: inputs change 1 ns after a rising edge, outputs are
  // sampled 2 ns after it.
  initial begin
    logic [7:0]  w8;
    logic [15:0] w16;
    logic [10:0] exp_o;
    logic [10:0] exp_v;

    passed    = 0;
    total     = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    lsb_first = 1'b0;
    hold      = 1'b0;

    // ---- 1: reset with in_valid asserted ----
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk($sformatf("t1_rst_ready_%0d", i), in_ready, 1);
      chk($sformatf("t1_rst_valid_%0d", i), serial_valid, 0);
      chk($sformatf("t1_rst_busy_%0d", i), busy, 0);
      chk($sformatf("t1_rst_out_%0d", i), serial_out, 0);
    end
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      chk($sformatf("t1_idle_busy_%0d", i), busy, 0);
      chk($sformatf("t1_idle_valid_%0d", i), serial_valid, 0);
      chk($sformatf("t1_idle_last_%0d", i), serial_last, 0);
    end

    // ---- 2: 0xC4 MSB-first ----
    w8 = 8'hC4;
    lsb_first = 1'b0;
    @(posedge clk); #1; in_valid = 1'b1; in_data = w8;
    @(posedge clk); #1; in_valid = 1'b0;
    #1;
    chk("t2_pend_busy", busy, 1);
    chk("t2_pend_ready", in_ready, 0);
    chk("t2_pend_valid", serial_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      chk($sformatf("t2_valid_b%0d", i), serial_valid, 1);
      chk($sformatf("t2_out_b%0d", i), serial_out, w8[7-i]);
      chk($sformatf("t2_last_b%0d", i), serial_last, (i == 7));
    end
    @(posedge clk); #2;
    chk("t2_end_valid", serial_valid, 0);
    chk("t2_end_busy", busy, 0);

    // ---- 3: 0xC4 LSB-first, lsb_first toggled mid-frame ----
    lsb_first = 1'b1;
    @(posedge clk); #1; in_valid = 1'b1; in_data = w8;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 2) lsb_first = 1'b0;
      if (i == 5) lsb_first = 1'b1;
      #1;
      chk($sformatf("t3_valid_b%0d", i), serial_valid, 1);
      chk($sformatf("t3_out_b%0d", i), serial_out, w8[i]);
      chk($sformatf("t3_last_b%0d", i), serial_last, (i == 7));
    end
    lsb_first = 1'b0;
    @(posedge clk); #2;
    chk("t3_end_valid", serial_valid, 0);
    chk("t3_end_busy", busy, 0);

    // ---- 4: back-to-back 0x12, 0x34 ----
    w16 = 16'h1234;
    @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h12;
    @(posedge clk); #1; in_data = 8'h34;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) in_valid = 1'b0;
      #1;
      if (i == 0) chk("t4_ready_after_load", in_ready, 1);
      if (i == 1) begin
        chk("t4_ready_second_pend", in_ready, 0);
        chk("t4_busy_second_pend", busy, 1);
      end
      chk($sformatf("t4_valid_b%0d", i), serial_valid, 1);
      chk($sformatf("t4_out_b%0d", i), serial_out, w16[15-i]);
      chk($sformatf("t4_last_b%0d", i), serial_last, (i == 7) || (i == 15));
    end
    @(posedge clk); #2;
    chk("t4_end_valid", serial_valid, 0);
    chk("t4_end_busy", busy, 0);

    // ---- 5: 0xA5 MSB-first with a 3-cycle hold on the 3rd bit ----
    exp_o = 11'b10111100101;  // cycle 0 at MSB
    exp_v = 11'b11000111111;
    @(posedge clk); #1; in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int j = 0; j < 11; j++) begin
      @(posedge clk); #1;
      hold = (j >= 2) && (j <= 4);
      #1;
      chk($sformatf("t5_valid_c%0d", j), serial_valid, exp_v[10-j]);
      chk($sformatf("t5_out_c%0d", j), serial_out, exp_o[10-j]);
      chk($sformatf("t5_last_c%0d", j), serial_last, (j == 10));
    end
    hold = 1'b0;
    @(posedge clk); #2;
    chk("t5_end_valid", serial_valid, 0);
    chk("t5_end_busy", busy, 0);

    // ---- 6: reset during 5th bit of 0xF0 with 0x0F pending ----
    w8 = 8'hF0;
    @(posedge clk); #1; in_valid = 1'b1; in_data = w8;
    @(posedge clk); #1; in_data = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) in_valid = 1'b0;
      #1;
      chk($sformatf("t6_out_b%0d", i), serial_out, w8[7-i]);
    end
    chk("t6_pre_ready", in_ready, 0);
    chk("t6_pre_busy", busy, 1);
    #1; reset = 1'b1;
    #1;
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_out", serial_out, 0);
    chk("t6_rst_valid", serial_valid, 0);
    chk("t6_rst_last", serial_last, 0);
    chk("t6_rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      chk($sformatf("t6_post_valid_%0d", i), serial_valid, 0);
      chk($sformatf("t6_post_busy_%0d", i), busy, 0);
    end
    // A fresh word after the abort starts a clean frame.
    @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h81;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    chk("t6_new_valid", serial_valid, 1);
    chk("t6_new_out_b0", serial_out, 1);
    @(posedge clk); #2;
    chk("t6_new_out_b1", serial_out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
